// File: rtl/nram_scan_reader_if.sv
// nram_scan_reader_if: valid/ready word stream carrying one NRAM word and its address.
// master drives valid/data/addr and samples ready; slave is the consumer side.
interface nram_scan_reader_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 1
);
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_out_data;
    logic [AW-1:0]    io_out_addr;

    modport master (
        output io_out_valid,
        output io_out_data,
        output io_out_addr,
        input  io_out_ready
    );

    modport slave (
        input  io_out_valid,
        input  io_out_data,
        input  io_out_addr,
        output io_out_ready
    );
endinterface : nram_scan_reader_if

// File: rtl/nram_scan_reader.sv
// nram_scan_reader: snapshots all NRAM words on io_start and streams them out
// lowest address first over a valid/ready interface.
// Optional feature macro: NRAM_RD_CHECKSUM_EN adds io_checksum, the running XOR
// of the words transferred in the current scan.
module nram_scan_reader #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DEPTH*WIDTH-1:0] io_Qbus,
    input  logic                   io_start,
    output logic                   io_busy,
    output logic                   io_done,
`ifdef NRAM_RD_CHECKSUM_EN
    output logic [WIDTH-1:0]       io_checksum,
`endif
    nram_scan_reader_if.master     out
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_e;

    state_e                       state_q, state_d;
    logic [AW-1:0]                addr_q, addr_d;
    logic [DEPTH-1:0][WIDTH-1:0]  snap_q, snap_d;
    logic                         valid_q, valid_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic [WIDTH-1:0]             cur_word_c;
    logic                         xfer_c;
`ifdef NRAM_RD_CHECKSUM_EN
    logic [WIDTH-1:0]             csum_q, csum_d;
`endif

    // Word currently presented: snapshot indexed by the address register only.
    assign cur_word_c = snap_q[addr_q];
    assign xfer_c     = valid_q & out.io_out_ready;

    // Next-state, address, snapshot and output-flag computation.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        snap_d  = snap_q;
`ifdef NRAM_RD_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (io_start) begin
                    snap_d  = io_Qbus;
                    addr_d  = '0;
                    state_d = S_SCAN;
`ifdef NRAM_RD_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_SCAN: begin
                if (xfer_c) begin
`ifdef NRAM_RD_CHECKSUM_EN
                    csum_d = csum_q ^ cur_word_c;
`endif
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase
        // Output flags follow the next state so they come straight from flops.
        valid_d = (state_d == S_SCAN);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers; reset aborts any scan in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef NRAM_RD_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef NRAM_RD_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign out.io_out_valid = valid_q;
    assign out.io_out_data  = cur_word_c;
    assign out.io_out_addr  = addr_q;
    assign io_busy          = busy_q;
    assign io_done          = done_q;
`ifdef NRAM_RD_CHECKSUM_EN
    assign io_checksum      = csum_q;
`endif

endmodule : nram_scan_reader

// File: tb/tb_nram_scan_reader.sv
// tb_nram_scan_reader: scoreboard bench for nram_scan_reader (WIDTH=8, DEPTH=2).
// Stimulus pushes the expected (addr, data) words; a negedge monitor compares
// every presented word against the queue head and pops on transfer.
module tb_nram_scan_reader;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned AW    = 1;

    logic                   clk;
    logic                   reset;
    logic [DEPTH*WIDTH-1:0] io_Qbus;
    logic                   io_start;
    logic                   io_busy;
    logic                   io_done;
`ifdef NRAM_RD_CHECKSUM_EN
    logic [WIDTH-1:0]       io_checksum;
`endif

    nram_scan_reader_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    nram_scan_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .io_Qbus     (io_Qbus),
        .io_start    (io_start),
        .io_busy     (io_busy),
        .io_done     (io_done),
`ifdef NRAM_RD_CHECKSUM_EN
        .io_checksum (io_checksum),
`endif
        .out         (bus)
    );

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_total  = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    int   d0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for the done pulse; leaves time just after the DONE edge.
    task automatic wait_done(input string name);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (io_done) break;
        end
        check(name, 32'(io_done), 32'd1);
    endtask

    // Monitor: every presented word must match the scoreboard head; pop on transfer.
    always @(negedge clk) begin
        if (!reset) begin
            if (io_done) done_cnt++;
            if (bus.io_out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(exp_q.size() != 0), 32'd1);
                end else begin
                    check("sb_addr", 32'(bus.io_out_addr), 32'(exp_q[0].addr));
                    check("sb_data", 32'(bus.io_out_data), 32'(exp_q[0].data));
                    if (bus.io_out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b0;
        io_start         = 1'b0;
        io_Qbus          = '0;
        bus.io_out_ready = 1'b0;

        // Reset asserted mid-cycle, then idle.
        #3 reset = 1'b1;
        #1;
        check("rst_busy",  32'(io_busy),          32'd0);
        check("rst_valid", 32'(bus.io_out_valid), 32'd0);
        check("rst_done",  32'(io_done),          32'd0);
        check("rst_data",  32'(bus.io_out_data),  32'h00);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("idle_valid", 32'(bus.io_out_valid), 32'd0);

        // Basic scan with cycle-accurate timing.
        io_Qbus          = 16'hB2A1;
        bus.io_out_ready = 1'b1;
        push(1'b0, 8'hA1);
        push(1'b1, 8'hB2);
        d0       = done_cnt;
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        check("basic_c1_valid", 32'(bus.io_out_valid), 32'd1);
        check("basic_c1_busy",  32'(io_busy),          32'd1);
        check("basic_c1_addr",  32'(bus.io_out_addr),  32'd0);
        check("basic_c1_data",  32'(bus.io_out_data),  32'hA1);
        tick();
        check("basic_c2_addr",  32'(bus.io_out_addr),  32'd1);
        check("basic_c2_data",  32'(bus.io_out_data),  32'hB2);
        tick();
        check("basic_c3_done",  32'(io_done),          32'd1);
        check("basic_c3_valid", 32'(bus.io_out_valid), 32'd0);
        check("basic_c3_busy",  32'(io_busy),          32'd1);
        tick();
        check("basic_c4_busy",  32'(io_busy),          32'd0);
        check("basic_c4_done",  32'(io_done),          32'd0);
        check("basic_done_cnt", 32'(done_cnt - d0),    32'd1);
        check("basic_sb_empty", 32'(exp_q.size()),     32'd0);

        // Backpressure with io_Qbus changing under the snapshot.
        tick();
        io_Qbus          = 16'h2211;
        bus.io_out_ready = 1'b0;
        push(1'b0, 8'h11);
        push(1'b1, 8'h22);
        d0       = done_cnt;
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        io_Qbus  = 16'hFFEE;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(bus.io_out_valid), 32'd1);
            check("bp_addr",  32'(bus.io_out_addr),  32'd0);
            check("bp_data",  32'(bus.io_out_data),  32'h11);
            if (i < 2) tick();
        end
        bus.io_out_ready = 1'b1;
        wait_done("bp_done_seen");
        tick();
        check("bp_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("bp_sb_empty", 32'(exp_q.size()),  32'd0);

        // Start while busy is ignored.
        io_Qbus = 16'h4433;
        push(1'b0, 8'h33);
        push(1'b1, 8'h44);
        d0       = done_cnt;
        io_start = 1'b1;
        tick();
        tick();
        io_start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("busy_start_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("busy_start_idle",     32'(io_busy),       32'd0);
        check("busy_start_sb_empty", 32'(exp_q.size()),  32'd0);

        // Reset after the first transfer aborts the scan.
        io_Qbus = 16'h6655;
        push(1'b0, 8'h55);
        d0       = done_cnt;
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        tick();
        check("abort_pre_addr", 32'(bus.io_out_addr), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("abort_valid", 32'(bus.io_out_valid), 32'd0);
        check("abort_busy",  32'(io_busy),          32'd0);
        check("abort_addr",  32'(bus.io_out_addr),  32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("abort_no_done",  32'(done_cnt - d0),  32'd0);
        check("abort_sb_empty", 32'(exp_q.size()),   32'd0);
        io_Qbus = 16'h8877;
        push(1'b0, 8'h77);
        push(1'b1, 8'h88);
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        check("rescan_addr", 32'(bus.io_out_addr), 32'd0);
        wait_done("rescan_done_seen");
        tick();
        check("rescan_done_cnt", 32'(done_cnt - d0), 32'd1);

`ifdef NRAM_RD_CHECKSUM_EN
        // Running XOR checksum, then cleared by the next scan.
        io_Qbus = 16'h0F5A;
        push(1'b0, 8'h5A);
        push(1'b1, 8'h0F);
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        check("csum_cleared_start", 32'(io_checksum), 32'h00);
        wait_done("csum1_done_seen");
        check("csum1_value", 32'(io_checksum), 32'h55);
        tick();
        check("csum1_hold", 32'(io_checksum), 32'h55);
        io_Qbus = 16'h0000;
        push(1'b0, 8'h00);
        push(1'b1, 8'h00);
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        wait_done("csum2_done_seen");
        check("csum2_value", 32'(io_checksum), 32'h00);
        tick();
`endif

        tick();
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_nram_scan_reader
